pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Takes hazard information from ID, EX and MEM and drives the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three cases: load-use stalls, flush on a branch taken in EX, and whole-pipeline freeze while a multi-cycle data memory is not ready.
- Includes a watchdog that halts the core on a memory timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for a 5-stage RISC-V pipeline
//               (IF, ID, EX, MEM, WB). Resolves load-use stalls, taken-branch
//               flushes and whole-pipeline freezes while a multi-cycle data
//               memory is busy. A watchdog halts the core when the memory
//               stays busy for MEM_TIMEOUT consecutive cycles.
//
// Ports       : clk, reset (sync, active-low)
//               ID hazard inputs  : id_valid, id_rs1, id_rs2, id_uses_rs2
//               EX hazard inputs  : ex_rd, ex_memread, ex_branch_taken
//               MEM hazard inputs : mem_req, dmem_ready
//               Pipeline controls : pc_we, pc_sel_branch, if_id_we,
//                                   if_id_flush, id_ex_we, id_ex_flush,
//                                   ex_mem_we, mem_wb_bubble
//               Status            : halted, stall_cycles, flush_count
//
// Options     : HAZARD_PERF_CNT_EN - when defined, stall_cycles/flush_count
//               are saturating counters; otherwise both are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             pc_sel_branch,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // wait_cnt holds the number of frozen cycles already completed; the
    // cycle in which it equals this value is the MEM_TIMEOUT-th one.
    localparam logic [WAIT_W-1:0] c_last_wait = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_branch_pending;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_active;
    logic w_freeze;
    logic w_branch;
    logic w_lu_stall;

    assign w_load_use  = ex_memread & (ex_rd != 5'd0) & id_valid &
                         ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign w_mem_stall = mem_req & ~dmem_ready;
    assign w_active    = reset & (r_state != S_HALT);

    // In MEM_WAIT the freeze holds until the memory answers; mem_req is not
    // re-examined because the MEM stage itself is frozen.
    assign w_freeze    = w_active &
                         (((r_state == S_RUN)      & w_mem_stall) |
                          ((r_state == S_MEM_WAIT) & ~dmem_ready));

    // A branch seen while the memory was busy is replayed on the release cycle.
    assign w_branch    = w_active & ~w_freeze & (ex_branch_taken | r_branch_pending);
    assign w_lu_stall  = w_active & ~w_freeze & ~w_branch & w_load_use;

    assign halted      = (r_state == S_HALT);

    // Mealy outputs: defaults describe the frozen/halted pipeline.
    always_comb begin
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_we      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_we      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_bubble = 1'b1;
        if (!reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_branch) begin
            pc_we         = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_we      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_we      = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_we     = 1'b1;
            mem_wb_bubble = 1'b0;
        end else if (w_lu_stall) begin
            id_ex_we      = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_we     = 1'b1;
            mem_wb_bubble = 1'b0;
        end else if (w_active & ~w_freeze) begin
            pc_we         = 1'b1;
            if_id_we      = 1'b1;
            id_ex_we      = 1'b1;
            ex_mem_we     = 1'b1;
            mem_wb_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= S_RUN;
            r_branch_pending <= 1'b0;
            r_wait_cnt       <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_branch_pending <= ex_branch_taken;
                        r_wait_cnt       <= WAIT_W'(1);
                        r_state          <= (MEM_TIMEOUT <= 1) ? S_HALT : S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state          <= S_RUN;
                        r_branch_pending <= 1'b0;
                        r_wait_cnt       <= '0;
                    end else if (r_wait_cnt >= c_last_wait) begin
                        r_state          <= S_HALT;
                    end else begin
                        r_wait_cnt       <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    assign w_stall_inc = w_freeze | w_lu_stall;
    assign w_flush_inc = w_branch;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire
